fence_drain_ctrl: RTL and testbench

FENCE_DRAIN_CTRL -- requirements
Module: fence_drain_ctrl

---
 rtl/fence_ctrl_pkg.sv | 14 +
 rtl/st_outstanding_cnt.sv | 50 +++++
 rtl/fence_drain_ctrl.sv | 108 ++++++++++
 tb/tb_fence_drain_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/fence_ctrl_pkg.sv
// Shared types and defaults for the fence drain controller.
package fence_ctrl_pkg;

    localparam int MAX_OUTSTANDING_DEF = 2;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DRAIN    = 3'd1,
        S_DC_FLUSH = 3'd2,
        S_IC_FLUSH = 3'd3,
        S_ACK      = 3'd4
    } fence_state_e;

endpackage

// File: rtl/st_outstanding_cnt.sv
// In-flight store counter: accepts stores while below the limit and the
// fence FSM is idle, retires one per completion ack, and flags underflow.
module st_outstanding_cnt
    import fence_ctrl_pkg::*;
#(
    parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             busy,
    input  logic             st_issue,
    input  logic             st_done,
    output logic             st_stall,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] cnt_nxt,
    output logic             err
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    logic accept;
    logic underflow;

    // Stall at the limit or whenever a fence is in progress; next count.
    always_comb begin
        st_stall  = (cnt == CNT_MAX) | busy;
        accept    = st_issue & ~st_stall;
        underflow = 1'b0;
        cnt_nxt   = cnt;
        if (accept & ~st_done) begin
            cnt_nxt = cnt + CNT_W'(1);
        end else if (~accept & st_done) begin
            if (cnt == '0) underflow = 1'b1;
            else           cnt_nxt   = cnt - CNT_W'(1);
        end
    end

    // Count register and sticky underflow flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            if (underflow) err <= 1'b1;
        end
    end

endmodule

// File: rtl/fence_drain_ctrl.sv
// FENCE / FENCE.I sequencer: blocks store issue, waits for the store buffer
// and in-flight stores to drain, optionally flushes the dcache, pulses the
// icache flush for FENCE.I, then acknowledges.
// Optional feature: define FENCE_DCACHE_FLUSH_EN to insert a dcache flush
// phase after drain.
module fence_drain_ctrl
    import fence_ctrl_pkg::*;
#(
    parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             fence_req_i,
    input  logic             fence_i_i,
    output logic             fence_ack_o,
    input  logic             st_issue_i,
    input  logic             st_done_i,
    output logic             st_stall_o,
    input  logic             sb_empty_i,
    output logic             dcache_flush_o,
    input  logic             dcache_flush_ack_i,
    output logic             icache_flush_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] outstanding_o,
    output logic             err_o
);

    fence_state_e     state, state_nxt;
    logic             is_fence_i;
    logic             busy;
    logic             drained;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    assign busy = (state != S_IDLE);

    st_outstanding_cnt #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .CNT_W           (CNT_W)
    ) u_cnt (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .busy     (busy),
        .st_issue (st_issue_i),
        .st_done  (st_done_i),
        .st_stall (st_stall_o),
        .cnt      (cnt),
        .cnt_nxt  (cnt_nxt),
        .err      (err_o)
    );

    // A completion arriving in the same cycle as the last check counts, so
    // the final store ack retires DRAIN immediately rather than a cycle late.
    assign drained = sb_empty_i & (cnt_nxt == '0);

    // Next-state logic for the fence sequence.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (fence_req_i) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (drained) begin
`ifdef FENCE_DCACHE_FLUSH_EN
                    state_nxt = S_DC_FLUSH;
`else
                    state_nxt = is_fence_i ? S_IC_FLUSH : S_ACK;
`endif
                end
            end
`ifdef FENCE_DCACHE_FLUSH_EN
            S_DC_FLUSH: begin
                if (dcache_flush_ack_i) state_nxt = is_fence_i ? S_IC_FLUSH : S_ACK;
            end
`endif
            S_IC_FLUSH: state_nxt = S_ACK;
            S_ACK:      state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // State register; the FENCE.I qualifier is captured when the request is taken.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= S_IDLE;
            is_fence_i <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && fence_req_i) is_fence_i <= fence_i_i;
        end
    end

`ifdef FENCE_DCACHE_FLUSH_EN
    assign dcache_flush_o = (state == S_DC_FLUSH);
`else
    // Without the flush phase the dcache ack has no meaning here.
    logic unused_dack;
    assign unused_dack    = dcache_flush_ack_i;
    assign dcache_flush_o = 1'b0;
`endif

    assign icache_flush_o = (state == S_IC_FLUSH);
    assign fence_ack_o    = (state == S_ACK);
    assign busy_o         = busy;
    assign outstanding_o  = cnt;

endmodule

// File: tb/tb_fence_drain_ctrl.sv
// Directed bench for fence_drain_ctrl with a queue-based reference model
// checked every cycle, plus hand-computed literal checks.
module tb_fence_drain_ctrl;

    localparam int MAX = 2;
    localparam int CW  = $clog2(MAX + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fence_req = 1'b0, fence_i = 1'b0;
    logic          st_issue = 1'b0, st_done = 1'b0, sb_empty = 1'b1;
    logic          dack = 1'b0;
    logic          fence_ack, st_stall, dflush, iflush, busy, err;
    logic [CW-1:0] outstanding;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fence_drain_ctrl #(.MAX_OUTSTANDING(MAX), .CNT_W(CW)) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .fence_req_i        (fence_req),
        .fence_i_i          (fence_i),
        .fence_ack_o        (fence_ack),
        .st_issue_i         (st_issue),
        .st_done_i          (st_done),
        .st_stall_o         (st_stall),
        .sb_empty_i         (sb_empty),
        .dcache_flush_o     (dflush),
        .dcache_flush_ack_i (dack),
        .icache_flush_o     (iflush),
        .busy_o             (busy),
        .outstanding_o      (outstanding),
        .err_o              (err)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    // Fence progress is tracked as: waiting for drain, waiting for a dcache
    // ack, then a queue of remaining one-cycle output events (1=icache, 2=ack).
    int m_cnt;
    bit m_err, m_on, m_wait, m_dc, m_fi, e_stall, acc;
    int tail[$];

    task automatic push_tail();
        if (m_fi) tail.push_back(1);
        tail.push_back(2);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            m_cnt = 0; m_err = 0; m_on = 0; m_wait = 0; m_dc = 0; m_fi = 0;
            tail.delete();
            chk("rst_outputs", {fence_ack, st_stall, dflush, iflush, busy, err, 26'(outstanding)}, 0);
        end else begin
            e_stall = (m_cnt == MAX) || m_on;
            chk("m_stall",  st_stall,    e_stall);
            chk("m_busy",   busy,        m_on);
            chk("m_cnt",    outstanding, m_cnt);
            chk("m_err",    err,         m_err);
            chk("m_dflush", dflush,      m_dc);
            chk("m_iflush", iflush,      tail.size() > 0 && tail[0] == 1);
            chk("m_ack",    fence_ack,   tail.size() > 0 && tail[0] == 2);
            // advance model to the next cycle
            acc = st_issue && !e_stall;
            if (acc && !st_done) m_cnt++;
            else if (!acc && st_done) begin
                if (m_cnt == 0) m_err = 1;
                else            m_cnt--;
            end
            if (!m_on) begin
                if (fence_req) begin m_on = 1; m_wait = 1; m_fi = fence_i; end
            end else if (m_wait) begin
                if (sb_empty && m_cnt == 0) begin
                    m_wait = 0;
`ifdef FENCE_DCACHE_FLUSH_EN
                    m_dc = 1;
`else
                    push_tail();
`endif
                end
            end else if (m_dc) begin
                if (dack) begin m_dc = 0; push_tail(); end
            end else begin
                void'(tail.pop_front());
                if (tail.size() == 0) m_on = 0;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        repeat (3) tick();
        rst_n = 1'b1;
        chk("rst_busy", busy, 0);
        chk("rst_cnt", outstanding, 0);
        chk("rst_stall", st_stall, 0);
        chk("rst_err", err, 0);

        // three back-to-back issues at MAX=2: 1,2,2 and third blocked
        st_issue = 1; tick();
        chk("iss1_cnt", outstanding, 1); chk("iss1_stall", st_stall, 0);
        tick();
        chk("iss2_cnt", outstanding, 2); chk("iss2_stall", st_stall, 1);
        tick();
        chk("iss3_cnt", outstanding, 2);
        st_issue = 0;

        // simultaneous issue+done keeps the count; underflow sets err
        st_done = 1; tick();
        chk("dn_cnt", outstanding, 1);
        st_issue = 1; tick();
        chk("both_cnt", outstanding, 1);
        st_issue = 0; tick();
        chk("dn0_cnt", outstanding, 0); chk("dn0_err", err, 0);
        tick();
        chk("uf_cnt", outstanding, 0); chk("uf_err", err, 1);
        st_done = 0; tick();
        chk("err_sticky", err, 1);
        rst_n = 0; tick(); tick(); rst_n = 1;
        chk("err_cleared", err, 0);

        // minimum latency plain FENCE: request N, ack N+2
        fence_req = 1; tick();
        chk("lat_busy", busy, 1); chk("lat_ack_n1", fence_ack, 0);
        tick();
        chk("lat_ack_n2", fence_ack, 1);
        fence_req = 0; tick();
        chk("lat_idle", busy, 0); chk("lat_ack_off", fence_ack, 0);

        // FENCE.I without dcache flush: icache pulse then ack
        fence_req = 1; fence_i = 1; dack = 1; tick();
        dack = 0; tick();
        chk("fi_iflush", iflush, 1); chk("fi_ack0", fence_ack, 0);
        chk("fi_dflush", dflush, 0);
        tick();
        chk("fi_iflush_off", iflush, 0); chk("fi_ack", fence_ack, 1);
        fence_req = 0; fence_i = 0; tick();

        // drain with two outstanding stores completing two cycles apart
        st_issue = 1; tick(); tick(); st_issue = 0;
        chk("dr_cnt2", outstanding, 2);
        fence_req = 1; tick();
        chk("dr_busy", busy, 1); chk("dr_stall", st_stall, 1);
        st_done = 1; tick();
        chk("dr_cnt1", outstanding, 1); chk("dr_ack_a", fence_ack, 0);
        st_done = 0; st_issue = 1; tick();
        chk("dr_blocked", outstanding, 1); chk("dr_ack_b", fence_ack, 0);
        st_issue = 0; st_done = 1; tick();
        chk("dr_ack", fence_ack, 1); chk("dr_cnt0", outstanding, 0);
        st_done = 0; fence_req = 0; tick();
        chk("dr_idle", busy, 0);

        // store buffer not empty holds DRAIN
        sb_empty = 0; fence_req = 1; repeat (3) tick();
        chk("sb_hold_busy", busy, 1); chk("sb_hold_ack", fence_ack, 0);
        sb_empty = 1; tick();
        chk("sb_ack", fence_ack, 1);
        // request held past ack: IDLE for one cycle, then a new fence
        tick();
        chk("b2b_gap", busy, 0);
        tick();
        chk("b2b_busy", busy, 1);
        fence_req = 0; tick();
        chk("b2b_ack", fence_ack, 1);
        tick();

`ifdef FENCE_DCACHE_FLUSH_EN
        // FENCE.I with dcache flush: ack arrives on the 4th flush cycle
        fence_req = 1; fence_i = 1; tick(); tick();
        chk("dc_flush_on", dflush, 1);
        tick(); tick(); tick();
        chk("dc_flush_hold", dflush, 1);
        dack = 1; tick(); dack = 0;
        chk("dc_flush_off", dflush, 0); chk("dc_iflush", iflush, 1);
        tick();
        chk("dc_ack", fence_ack, 1); chk("dc_iflush_off", iflush, 0);
        fence_req = 0; fence_i = 0; tick();
        // reset while flushing
        fence_req = 1; tick(); tick();
        chk("dc_rst_pre", dflush, 1);
`else
        // reset while draining
        sb_empty = 0; fence_req = 1; tick();
        chk("rst_mid_busy", busy, 1);
`endif
        #2 rst_n = 0;
        #1;
        chk("async_busy", busy, 0); chk("async_dflush", dflush, 0);
        chk("async_ack", fence_ack, 0); chk("async_stall", st_stall, 0);
        fence_req = 0; fence_i = 0; sb_empty = 1;
        tick(); rst_n = 1;
        repeat (3) tick();
        chk("post_rst_ack", fence_ack, 0); chk("post_rst_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
